// File: rtl/coherence_req_scheduler_pkg.sv
// Shared configuration for the L2 coherence request scheduler: widths, MESI and FSM
// encodings, and the directory request payload.
package cache_config;

    localparam int unsigned ADDRESS_WIDTH          = 32;
    localparam int unsigned MAIN_MEMORY_DATA_WIDTH = 64;
    localparam int unsigned MESI_STATE_WIDTH       = 2;
    localparam int unsigned NUM_REQUESTERS         = 4;
    localparam int unsigned REQ_IDX_W              = 2;

    typedef enum logic [MESI_STATE_WIDTH-1:0] {
        MESI_INVALID   = 2'd0,
        MESI_SHARED    = 2'd1,
        MESI_EXCLUSIVE = 2'd2,
        MESI_MODIFIED  = 2'd3
    } mesi_state_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    // Operation latched at grant time and presented to the directory
    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0]                                  addr;
        logic [NUM_REQUESTERS-1:0][MAIN_MEMORY_DATA_WIDTH-1:0]     data;
        logic                                                      rd;
        logic                                                      wr;
    } dir_req_t;

    function automatic logic [REQ_IDX_W-1:0] onehot_to_idx(input logic [NUM_REQUESTERS-1:0] oh);
        logic [REQ_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (oh[i]) idx = REQ_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/coherence_req_scheduler_rr_picker4.sv
// Combinational round-robin picker: first set request at or after the pointer wins.
module rr_picker4
    import cache_config::*;
(
    input  logic [NUM_REQUESTERS-1:0] i_req,
    input  logic [REQ_IDX_W-1:0]      i_ptr,
    output logic [NUM_REQUESTERS-1:0] o_grant_c,
    output logic                      o_valid_c
);

    logic [REQ_IDX_W-1:0] w_idx;

    // Scan farthest-first so the candidate closest to the pointer overwrites the rest
    always_comb begin
        o_grant_c = '0;
        w_idx     = '0;
        for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
            w_idx = i_ptr + REQ_IDX_W'(k);
            if (i_req[w_idx]) o_grant_c = NUM_REQUESTERS'(1) << w_idx;
        end
    end

    assign o_valid_c = |i_req;

endmodule

// File: rtl/coherence_req_scheduler.sv
// Arbitrates four L2 read/write coherence requests onto one directory port and
// sequences each operation through issue, verify-acknowledge and completion.
module coherence_req_scheduler
    import cache_config::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQUESTERS-1:0]         req_read,
    input  logic [NUM_REQUESTERS-1:0]         req_write,
    input  logic [ADDRESS_WIDTH-1:0]          req_addr_a,
    input  logic [ADDRESS_WIDTH-1:0]          req_addr_b,
    input  logic [ADDRESS_WIDTH-1:0]          req_addr_c,
    input  logic [ADDRESS_WIDTH-1:0]          req_addr_d,
    input  logic [MAIN_MEMORY_DATA_WIDTH-1:0] req_data_a,
    input  logic [MAIN_MEMORY_DATA_WIDTH-1:0] req_data_b,
    input  logic [MAIN_MEMORY_DATA_WIDTH-1:0] req_data_c,
    input  logic [MAIN_MEMORY_DATA_WIDTH-1:0] req_data_d,
    output logic [ADDRESS_WIDTH-1:0]          dir_addr,
    output logic [MAIN_MEMORY_DATA_WIDTH-1:0] dir_data_a,
    output logic [MAIN_MEMORY_DATA_WIDTH-1:0] dir_data_b,
    output logic [MAIN_MEMORY_DATA_WIDTH-1:0] dir_data_c,
    output logic [MAIN_MEMORY_DATA_WIDTH-1:0] dir_data_d,
    output logic                              dir_read_update,
    output logic                              dir_write_update,
    output logic                              dir_ack,
    input  logic                              dir_verify,
    input  logic [MESI_STATE_WIDTH-1:0]       dir_mesi_state,
    output logic [NUM_REQUESTERS-1:0]         grant,
    output logic [NUM_REQUESTERS-1:0]         done,
    output logic [MESI_STATE_WIDTH-1:0]       mesi_state_out,
    output logic                              timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    sched_state_e                      r_state,   w_state_nxt;
    logic [REQ_IDX_W-1:0]              r_rr_ptr,  w_rr_ptr_nxt;
    logic [REQ_IDX_W-1:0]              r_owner,   w_owner_nxt;
    logic [CNT_W-1:0]                  r_cnt,     w_cnt_nxt;
    logic [NUM_REQUESTERS-1:0]         r_grant,   w_grant_nxt;
    logic [NUM_REQUESTERS-1:0]         r_done,    w_done_nxt;
    dir_req_t                          r_dir_req, w_dir_req_nxt;
    logic                              r_ack,     w_ack_nxt;
    logic [MESI_STATE_WIDTH-1:0]       r_mesi,    w_mesi_nxt;
    logic                              r_timeout, w_timeout_nxt;

    logic [NUM_REQUESTERS-1:0]                          w_pick;
    logic                                               w_pick_valid;
    logic [REQ_IDX_W-1:0]                               w_pick_idx;
    logic [NUM_REQUESTERS-1:0][ADDRESS_WIDTH-1:0]       w_addr_vec;

    rr_picker4 u_picker (
        .i_req     (req_read | req_write),
        .i_ptr     (r_rr_ptr),
        .o_grant_c (w_pick),
        .o_valid_c (w_pick_valid)
    );

    assign w_pick_idx = onehot_to_idx(w_pick);
    assign w_addr_vec = {req_addr_d, req_addr_c, req_addr_b, req_addr_a};

    // Next-state and next-output logic; every register holds unless a transition says otherwise
    always_comb begin
        w_state_nxt   = r_state;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_owner_nxt   = r_owner;
        w_cnt_nxt     = r_cnt;
        w_grant_nxt   = r_grant;
        w_done_nxt    = r_done;
        w_dir_req_nxt = r_dir_req;
        w_ack_nxt     = r_ack;
        w_mesi_nxt    = r_mesi;
        w_timeout_nxt = r_timeout;

        unique case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt        = ST_ISSUE;
                    w_grant_nxt        = w_pick;
                    w_owner_nxt        = w_pick_idx;
                    w_cnt_nxt          = '0;
                    w_dir_req_nxt.addr = w_addr_vec[w_pick_idx];
                    w_dir_req_nxt.data = {req_data_d, req_data_c, req_data_b, req_data_a};
                    // A requester asking for both is served as a write
                    w_dir_req_nxt.wr   = req_write[w_pick_idx];
                    w_dir_req_nxt.rd   = ~req_write[w_pick_idx];
                end
            end
            ST_ISSUE: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (dir_verify) begin
                    w_state_nxt      = ST_ACK;
                    w_mesi_nxt       = dir_mesi_state;
                    w_dir_req_nxt.rd = 1'b0;
                    w_dir_req_nxt.wr = 1'b0;
                    w_ack_nxt        = 1'b1;
                end else if (w_cnt_nxt == CNT_LIMIT) begin
                    w_state_nxt      = ST_DONE;
                    w_mesi_nxt       = MESI_STATE_WIDTH'(MESI_INVALID);
                    w_timeout_nxt    = 1'b1;
                    w_dir_req_nxt.rd = 1'b0;
                    w_dir_req_nxt.wr = 1'b0;
                    w_done_nxt       = r_grant;
                end
            end
            ST_ACK: begin
                if (!dir_verify) begin
                    w_state_nxt = ST_DONE;
                    w_ack_nxt   = 1'b0;
                    w_done_nxt  = r_grant;
                end
            end
            ST_DONE: begin
                w_state_nxt   = ST_IDLE;
                w_done_nxt    = '0;
                w_timeout_nxt = 1'b0;
                w_grant_nxt   = '0;
                w_rr_ptr_nxt  = r_owner + REQ_IDX_W'(1);
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_grant   <= '0;
            r_done    <= '0;
            r_dir_req <= '0;
            r_ack     <= 1'b0;
            r_mesi    <= MESI_STATE_WIDTH'(MESI_INVALID);
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_owner   <= w_owner_nxt;
            r_cnt     <= w_cnt_nxt;
            r_grant   <= w_grant_nxt;
            r_done    <= w_done_nxt;
            r_dir_req <= w_dir_req_nxt;
            r_ack     <= w_ack_nxt;
            r_mesi    <= w_mesi_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign dir_addr         = r_dir_req.addr;
    assign dir_data_a       = r_dir_req.data[0];
    assign dir_data_b       = r_dir_req.data[1];
    assign dir_data_c       = r_dir_req.data[2];
    assign dir_data_d       = r_dir_req.data[3];
    assign dir_read_update  = r_dir_req.rd;
    assign dir_write_update = r_dir_req.wr;
    assign dir_ack          = r_ack;
    assign grant            = r_grant;
    assign done             = r_done;
    assign mesi_state_out   = r_mesi;
    assign timeout_err      = r_timeout;

endmodule

// File: tb/tb_coherence_req_scheduler.sv
// Bench for coherence_req_scheduler: directed scenarios plus randomized operations
// checked against a transaction-level arbitration/latency model.
module tb_coherence_req_scheduler;
    import cache_config::*;

    localparam int T  = 16;
    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = MAIN_MEMORY_DATA_WIDTH;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [3:0] req_read = '0, req_write = '0;
    logic [AW-1:0] req_addr [4];
    logic [DW-1:0] req_data [4];
    logic [AW-1:0] dir_addr;
    logic [DW-1:0] dir_data [4];
    logic dir_read_update, dir_write_update, dir_ack;
    logic dir_verify = 1'b0;
    logic [1:0] dir_mesi_state = '0;
    logic [3:0] grant, done;
    logic [1:0] mesi_state_out;
    logic timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int model_ptr = 0;

    typedef struct {
        int done_cyc;
        int strobe_cyc;
        logic [3:0] grant;
        logic rd;
        logic wr;
        logic [AW-1:0] addr;
        logic [3:0][DW-1:0] data;
        logic [3:0] done;
        logic [1:0] mesi;
        logic tout;
        logic [3:0] done_after;
        logic [3:0] grant_after;
    } obs_t;

    coherence_req_scheduler #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .req_read(req_read), .req_write(req_write),
        .req_addr_a(req_addr[0]), .req_addr_b(req_addr[1]),
        .req_addr_c(req_addr[2]), .req_addr_d(req_addr[3]),
        .req_data_a(req_data[0]), .req_data_b(req_data[1]),
        .req_data_c(req_data[2]), .req_data_d(req_data[3]),
        .dir_addr(dir_addr),
        .dir_data_a(dir_data[0]), .dir_data_b(dir_data[1]),
        .dir_data_c(dir_data[2]), .dir_data_d(dir_data[3]),
        .dir_read_update(dir_read_update), .dir_write_update(dir_write_update),
        .dir_ack(dir_ack), .dir_verify(dir_verify), .dir_mesi_state(dir_mesi_state),
        .grant(grant), .done(done), .mesi_state_out(mesi_state_out),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Round-robin reference: first pending requester at or after ptr, modulo 4
    function automatic int exp_winner(input logic [3:0] pend, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (pend[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        reset = 1'b0; req_read = '0; req_write = '0; dir_verify = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_ptr = 0;
    endtask

    // Plays the directory: verify high for cycles d..d+h after grant (never if d >= T)
    task automatic run_op(input int d, input int h, input logic [1:0] m,
                          input logic [3:0] drop, output obs_t o);
        o.done_cyc = -1; o.strobe_cyc = 0; o.grant = '0; o.rd = 0; o.wr = 0;
        o.addr = '0; o.data = '0; o.done = '0; o.mesi = '0; o.tout = 0;
        o.done_after = 4'hF; o.grant_after = 4'hF;
        dir_verify = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (n == 0) begin
                o.grant = grant; o.rd = dir_read_update; o.wr = dir_write_update;
                o.addr = dir_addr;
                for (int i = 0; i < 4; i++) o.data[i] = dir_data[i];
                req_read &= ~drop; req_write &= ~drop;
            end
            if (dir_read_update || dir_write_update) o.strobe_cyc++;
            if (done != 0) begin
                o.done_cyc = n; o.done = done; o.mesi = mesi_state_out; o.tout = timeout_err;
                break;
            end
            dir_verify = (d < T) && (n >= d) && (n <= d + h);
            dir_mesi_state = dir_verify ? m : 2'($urandom);
        end
        if (o.done_cyc >= 0) begin
            req_read &= ~o.done; req_write &= ~o.done;
            dir_verify = 1'($urandom);
            @(negedge clk);
            o.done_after = done; o.grant_after = grant;
        end
        dir_verify = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_read = 4'hF; dir_verify = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (grant !== 4'b0) begin n_errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        n_checks++; if (done !== 4'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0000", done); end
        n_checks++; if ({dir_read_update, dir_write_update, dir_ack} !== 3'b0) begin n_errors++; $display("FAIL reset_strobes: got %b expected 000", {dir_read_update, dir_write_update, dir_ack}); end
        n_checks++; if (dir_addr !== '0) begin n_errors++; $display("FAIL reset_addr: got %h expected 0", dir_addr); end
        n_checks++; if ((dir_data[0] | dir_data[1] | dir_data[2] | dir_data[3]) !== '0) begin n_errors++; $display("FAIL reset_data: got nonzero expected 0"); end
        n_checks++; if (mesi_state_out !== 2'd0) begin n_errors++; $display("FAIL reset_mesi: got %0d expected 0", mesi_state_out); end
        n_checks++; if (timeout_err !== 1'b0) begin n_errors++; $display("FAIL reset_tout: got %b expected 0", timeout_err); end
        apply_reset();
    endtask

    task automatic test_verify_idle();
        apply_reset();
        dir_verify = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if ({grant, done, dir_ack} !== 9'b0) begin n_errors++; $display("FAIL verify_idle: got %b expected 0", {grant, done, dir_ack}); end
        end
        dir_verify = 1'b0;
    endtask

    task automatic test_single_read();
        obs_t o;
        apply_reset();
        for (int i = 0; i < 4; i++) req_data[i] = DW'({$urandom, $urandom});
        req_addr[1] = AW'(32'h40); req_read = 4'b0010;
        run_op(0, 0, 2'd2, 4'b0, o);
        n_checks++; if (o.grant !== 4'b0010) begin n_errors++; $display("FAIL single_grant: got %b expected 0010", o.grant); end
        n_checks++; if ({o.rd, o.wr} !== 2'b10) begin n_errors++; $display("FAIL single_op: got %b expected 10", {o.rd, o.wr}); end
        n_checks++; if (o.addr !== AW'(32'h40)) begin n_errors++; $display("FAIL single_addr: got %h expected 40", o.addr); end
        n_checks++; if (o.strobe_cyc !== 1) begin n_errors++; $display("FAIL single_strobe_len: got %0d expected 1", o.strobe_cyc); end
        n_checks++; if (o.done_cyc !== 2) begin n_errors++; $display("FAIL single_latency: got %0d expected 2", o.done_cyc); end
        n_checks++; if (o.done !== 4'b0010) begin n_errors++; $display("FAIL single_done: got %b expected 0010", o.done); end
        n_checks++; if ({o.mesi, o.tout} !== {2'd2, 1'b0}) begin n_errors++; $display("FAIL single_result: got %b expected 100", {o.mesi, o.tout}); end
        n_checks++; if ({o.done_after, o.grant_after} !== 8'b0) begin n_errors++; $display("FAIL single_pulse: got %b expected 0", {o.done_after, o.grant_after}); end
    endtask

    task automatic test_all_four();
        obs_t o;
        apply_reset();
        for (int i = 0; i < 4; i++) req_addr[i] = AW'(32'h100 * (i + 1));
        req_read = 4'hF;
        for (int k = 0; k < 4; k++) begin
            run_op(0, 0, 2'd1, 4'b0, o);
            n_checks++; if (o.grant !== 4'(1 << k)) begin n_errors++; $display("FAIL all4_grant%0d: got %b expected %b", k, o.grant, 4'(1 << k)); end
            n_checks++; if (o.addr !== req_addr[k]) begin n_errors++; $display("FAIL all4_addr%0d: got %h expected %h", k, o.addr, req_addr[k]); end
        end
        req_read = 4'b1001;
        run_op(0, 0, 2'd1, 4'b0, o);
        n_checks++; if (o.grant !== 4'b0001) begin n_errors++; $display("FAIL all4_wrap: got %b expected 0001", o.grant); end
        req_read = '0;
    endtask

    task automatic test_read_write();
        obs_t o;
        apply_reset();
        req_read = 4'b0100; req_write = 4'b0100;
        run_op(1, 0, 2'd3, 4'b0, o);
        n_checks++; if ({o.rd, o.wr} !== 2'b01) begin n_errors++; $display("FAIL rw_op: got %b expected 01", {o.rd, o.wr}); end
        n_checks++; if (o.strobe_cyc !== 2) begin n_errors++; $display("FAIL rw_strobe_len: got %0d expected 2", o.strobe_cyc); end
        n_checks++; if ({o.done, o.mesi} !== {4'b0100, 2'd3}) begin n_errors++; $display("FAIL rw_result: got %b expected 010011", {o.done, o.mesi}); end
    endtask

    task automatic test_timeout();
        obs_t o;
        apply_reset();
        req_read = 4'b0001;
        run_op(T + 4, 0, 2'd3, 4'b0, o);
        n_checks++; if (o.done_cyc !== T) begin n_errors++; $display("FAIL tout_latency: got %0d expected %0d", o.done_cyc, T); end
        n_checks++; if (o.strobe_cyc !== T) begin n_errors++; $display("FAIL tout_strobe_len: got %0d expected %0d", o.strobe_cyc, T); end
        n_checks++; if ({o.done, o.mesi, o.tout} !== {4'b0001, 2'd0, 1'b1}) begin n_errors++; $display("FAIL tout_result: got %b expected 0001001", {o.done, o.mesi, o.tout}); end
        n_checks++; if (o.done_after !== 4'b0) begin n_errors++; $display("FAIL tout_pulse: got %b expected 0000", o.done_after); end
        req_read = 4'b0001;
        run_op(T - 1, 0, 2'd1, 4'b0, o);
        n_checks++; if (o.done_cyc !== T + 1) begin n_errors++; $display("FAIL tout_edge_latency: got %0d expected %0d", o.done_cyc, T + 1); end
        n_checks++; if ({o.mesi, o.tout} !== {2'd1, 1'b0}) begin n_errors++; $display("FAIL tout_edge_result: got %b expected 010", {o.mesi, o.tout}); end
    endtask

    task automatic test_ack_hold();
        obs_t o;
        apply_reset();
        req_read = 4'b1000;
        run_op(0, 3, 2'd2, 4'b0, o);
        n_checks++; if (o.done_cyc !== 5) begin n_errors++; $display("FAIL ackhold_latency: got %0d expected 5", o.done_cyc); end
        n_checks++; if ({o.done, o.mesi} !== {4'b1000, 2'd2}) begin n_errors++; $display("FAIL ackhold_result: got %b expected 100010", {o.done, o.mesi}); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        apply_reset();
        req_read = 4'b0010;
        run_op(0, 0, 2'd1, 4'b0, o);
        req_read = 4'b0100;
        @(negedge clk);
        n_checks++; if ({grant, dir_read_update} !== 5'b01001) begin n_errors++; $display("FAIL rstmid_issue: got %b expected 01001", {grant, dir_read_update}); end
        reset = 1'b0; req_read = 4'b0101;
        @(negedge clk);
        n_checks++; if ({grant, done, dir_read_update, dir_write_update, dir_ack, timeout_err} !== 12'b0) begin n_errors++; $display("FAIL rstmid_outputs: got %b expected 0", {grant, done, dir_read_update, dir_write_update, dir_ack, timeout_err}); end
        n_checks++; if ({dir_addr, mesi_state_out} !== '0) begin n_errors++; $display("FAIL rstmid_addr_mesi: got %h expected 0", {dir_addr, mesi_state_out}); end
        reset = 1'b1;
        run_op(0, 0, 2'd3, 4'b0, o);
        n_checks++; if (o.grant !== 4'b0001) begin n_errors++; $display("FAIL rstmid_priority: got %b expected 0001", o.grant); end
        req_read = '0;
    endtask

    task automatic test_random();
        obs_t o;
        int w, d, h, r, edc, esc;
        logic [1:0] m, em;
        logic [3:0] drop;
        logic ew, et;
        logic [AW-1:0] ea;
        logic [3:0][DW-1:0] ed;
        apply_reset();
        for (int it = 0; it < 80; it++) begin
            for (int i = 0; i < 4; i++) begin
                if (!(req_read[i] || req_write[i]) && ($urandom % 3 != 0)) begin
                    r = int'($urandom % 3);
                    req_read[i] = (r != 1); req_write[i] = (r != 0);
                    req_addr[i] = AW'($urandom); req_data[i] = DW'({$urandom, $urandom});
                end
            end
            if ((req_read | req_write) == 4'b0) begin
                r = int'($urandom % 4);
                req_read[r] = 1'b1; req_addr[r] = AW'($urandom); req_data[r] = DW'({$urandom, $urandom});
            end
            w  = exp_winner(req_read | req_write, model_ptr);
            ew = req_write[w]; ea = req_addr[w];
            for (int i = 0; i < 4; i++) ed[i] = req_data[i];
            r = int'($urandom % 8);
            d = (r == 0) ? T + 3 : (r == 1) ? T - 1 : int'($urandom % 3);
            h = int'($urandom % 4);
            m = 2'($urandom);
            drop = ($urandom % 4 == 0) ? 4'(1 << w) : 4'b0;
            edc = (d < T) ? d + h + 2 : T;
            esc = (d < T) ? d + 1 : T;
            em  = (d < T) ? m : 2'd0;
            et  = (d >= T);
            run_op(d, h, m, drop, o);
            n_checks++; if (o.grant !== 4'(1 << w)) begin n_errors++; $display("FAIL rnd%0d_grant: got %b expected %b", it, o.grant, 4'(1 << w)); end
            n_checks++; if ({o.rd, o.wr} !== {~ew, ew}) begin n_errors++; $display("FAIL rnd%0d_op: got %b expected %b", it, {o.rd, o.wr}, {~ew, ew}); end
            n_checks++; if (o.addr !== ea) begin n_errors++; $display("FAIL rnd%0d_addr: got %h expected %h", it, o.addr, ea); end
            n_checks++; if (o.data !== ed) begin n_errors++; $display("FAIL rnd%0d_data: got %h expected %h", it, o.data, ed); end
            n_checks++; if (o.strobe_cyc !== esc) begin n_errors++; $display("FAIL rnd%0d_strobe_len: got %0d expected %0d", it, o.strobe_cyc, esc); end
            n_checks++; if (o.done_cyc !== edc) begin n_errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", it, o.done_cyc, edc); end
            n_checks++; if (o.done !== 4'(1 << w)) begin n_errors++; $display("FAIL rnd%0d_done: got %b expected %b", it, o.done, 4'(1 << w)); end
            n_checks++; if ({o.mesi, o.tout} !== {em, et}) begin n_errors++; $display("FAIL rnd%0d_result: got %b expected %b", it, {o.mesi, o.tout}, {em, et}); end
            n_checks++; if ({o.done_after, o.grant_after} !== 8'b0) begin n_errors++; $display("FAIL rnd%0d_idle_gap: got %b expected 0", it, {o.done_after, o.grant_after}); end
            model_ptr = (w + 1) % 4;
        end
        req_read = '0; req_write = '0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin req_addr[i] = '0; req_data[i] = '0; end
        test_reset();
        test_verify_idle();
        test_single_read();
        test_all_four();
        test_read_write();
        test_timeout();
        test_ack_hold();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/coherence_req_scheduler.md
COHERENCE_REQ_SCHEDULER -- requirements
Module: coherence_req_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: max cycles the block waits for directory verify before aborting.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 req_read  in  4  per-L2 read-coherence request; bit0=L2a, bit1=L2b, bit2=L2c, bit3=L2d; held until matching done bit.
REQ-005 req_write  in  4  per-L2 write-update request, same bit mapping and hold rule.
REQ-006 req_addr_a/b/c/d  in  ADDRESS_WIDTH each  block address of the corresponding requester.
REQ-007 req_data_a/b/c/d  in  MAIN_MEMORY_DATA_WIDTH each  local block data of the corresponding requester.
REQ-008 dir_addr  out  ADDRESS_WIDTH  address presented to coherence directory.
REQ-009 dir_data_a/b/c/d  out  MAIN_MEMORY_DATA_WIDTH each  registered snapshot of all four req_data at grant.
REQ-010 dir_read_update / dir_write_update  out  1 each  directory operation strobes.
REQ-011 dir_ack  out  1  acknowledge of directory verify.
REQ-012 dir_verify  in  1  directory result valid.
REQ-013 dir_mesi_state  in  MESI_STATE_WIDTH  directory result.
REQ-014 grant  out  4  one-hot owner of the directory; zero when idle.
REQ-015 done  out  4  one-cycle one-hot completion pulse to the owner.
REQ-016 mesi_state_out  out  MESI_STATE_WIDTH  result, valid while done nonzero.
REQ-017 timeout_err  out  1  high with done when the operation aborted.

Function
REQ-018 FSM states IDLE, ISSUE, ACK, DONE; encoding in package.
REQ-019 IDLE: if any (req_read|req_write) bit set, select winner round-robin starting at rr_ptr, register grant, dir_addr, dir_data_*, op type; go ISSUE next cycle.
REQ-020 Requester with both read and write set issues write.
REQ-021 ISSUE: assert exactly one of dir_read_update/dir_write_update; increment wait counter each cycle.
REQ-022 ISSUE with dir_verify=1: capture dir_mesi_state, go ACK; strobes drop that edge.
REQ-023 ISSUE with counter reaching TIMEOUT_CYCLES and no verify: result forced MESI_INVALID, timeout flag set, go DONE.
REQ-024 ACK: dir_ack=1; remain until dir_verify=0, then go DONE.
REQ-025 DONE: pulse done[owner] one cycle, drive mesi_state_out/timeout_err, rr_ptr = owner+1 mod 4, clear grant, go IDLE.
REQ-026 Minimum request-to-done latency 4 cycles (IDLE sample, ISSUE, ACK, DONE) when verify arrives in first ISSUE cycle and drops one cycle after dir_ack.
REQ-027 Request bits deasserted before done are ignored once granted; operation completes normally.
REQ-028 New grant never issued in DONE; back-to-back operations separated by one IDLE cycle.
REQ-029 rr_ptr wraps 3->0; a requester waiting while others request is granted within 4 operations.
REQ-030 dir_verify high in IDLE or DONE is ignored.

Reset
REQ-031 reset=0: state IDLE, rr_ptr=0, counter=0, grant=0, done=0, all dir strobes=0, dir_ack=0, dir_addr=0, dir_data_*=0, mesi_state_out=MESI_INVALID, timeout_err=0.
REQ-032 reset mid-operation aborts without done pulse; directory strobes low the following cycle.

Structure
REQ-033 Package cache_config holds MESI state typedef, FSM state typedef, requester count 4; ADDRESS_WIDTH/MAIN_MEMORY_DATA_WIDTH come from existing packages.
REQ-034 Single sub-module rr_picker4 (combinational: request vector + pointer -> one-hot winner, valid).

Verification
REQ-035 Single read L2b addr 0x40, verify with EXCLUSIVE next cycle -> grant=0010, dir_read_update one cycle, done=0010 with EXCLUSIVE at 4 cycles.
REQ-036 All four read simultaneously after reset -> grant order a,b,c,d; rr_ptr wraps to 0.
REQ-037 L2c read+write simultaneously -> dir_write_update only, result MODIFIED passed through.
REQ-038 No dir_verify for 16 cycles -> done pulse, timeout_err=1, mesi_state_out=INVALID.
REQ-039 dir_verify held 3 cycles after dir_ack -> stays in ACK, done delayed 3 cycles.
REQ-040 reset=0 asserted in ISSUE -> no done, all outputs at reset values next cycle, next request served from L2a priority.
